// File: rtl/conv_read_scheduler_if.sv
// rtl/conv_read_scheduler_if.sv - command, weight, ftm and reader signal bundle of conv_read_scheduler
interface conv_read_scheduler_if #(
    parameter int B_SHAPE = 25,
    parameter int B_PASS  = 8
);
    logic               cmd_valid;
    logic               cmd_ready;
    logic [1:0]         cmd_stride;
    logic [1:0]         cmd_pad;
    logic [B_SHAPE-1:0] cmd_wei_shape;
    logic [B_SHAPE-1:0] cmd_ftm_shape;
    logic [B_PASS-1:0]  cmd_n_pass;
    logic               cmd_last_para;
    logic               ftm_ready;
    logic               ftm_release;
    logic               wei_req;
    logic               wei_done;
    logic               out_space;
    logic               rd_en;
    logic               rd_last;
    logic               rd_base_incr_en;
    logic [1:0]         stride;
    logic [1:0]         pad;
    logic [B_SHAPE-1:0] wei_shape;
    logic [B_SHAPE-1:0] ftm_shape;
    logic               busy;
    logic               done;
    logic [B_PASS-1:0]  pass_idx;
    logic               err;

    // scheduler side
    modport slave (
        input  cmd_valid, cmd_stride, cmd_pad, cmd_wei_shape, cmd_ftm_shape,
               cmd_n_pass, cmd_last_para, ftm_ready, wei_done, out_space, rd_last,
        output cmd_ready, ftm_release, wei_req, rd_en, rd_base_incr_en, stride, pad,
               wei_shape, ftm_shape, busy, done, pass_idx, err
    );

    // controller / reader / buffer side
    modport master (
        output cmd_valid, cmd_stride, cmd_pad, cmd_wei_shape, cmd_ftm_shape,
               cmd_n_pass, cmd_last_para, ftm_ready, wei_done, out_space, rd_last,
        input  cmd_ready, ftm_release, wei_req, rd_en, rd_base_incr_en, stride, pad,
               wei_shape, ftm_shape, busy, done, pass_idx, err
    );
endinterface

// File: rtl/conv_read_scheduler.sv
// rtl/conv_read_scheduler.sv - layer-tile job controller for the strided ftm reader; optional sweep watchdog under SCHED_WATCHDOG_EN
module conv_read_scheduler #(
    parameter int B_SHAPE = 25,
    parameter int B_PASS  = 8
`ifdef SCHED_WATCHDOG_EN
    ,
    parameter int TIMEOUT_CYC = 1048576
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    conv_read_scheduler_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_FTM,
        S_LOAD_WEI,
        S_WAIT_SPACE,
        S_SWEEP,
        S_DONE
    } state_t;

    state_t             state;
    state_t             state_nx;

    logic [1:0]         stride_q;
    logic [1:0]         pad_q;
    logic [B_SHAPE-1:0] wei_shape_q;
    logic [B_SHAPE-1:0] ftm_shape_q;
    logic [B_PASS-1:0]  pass_last_q;
    logic               last_para_q;
    logic [B_PASS-1:0]  pass_idx_q;
    logic               wei_sent;

    logic               last_pass;
    logic               wd_hit;
    logic               timed_out;

    logic               cmd_ready;
    logic               busy;
    logic               rd_en;
    logic               rd_base_incr_en;
    logic               wei_req;
    logic               done;
    logic               ftm_release;

    // pass_last_q holds n_pass-1 so a zero pass count behaves as a single pass
    assign last_pass = (pass_idx_q == pass_last_q);

    // state register, pass counter and wei_req entry tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            pass_idx_q <= '0;
            wei_sent   <= 1'b0;
        end else begin
            state    <= state_nx;
            wei_sent <= (state == S_LOAD_WEI);
            if (state == S_SWEEP && bus.rd_last && !last_pass) begin
                pass_idx_q <= pass_idx_q + 1'b1;
            end else if (state == S_DONE) begin
                pass_idx_q <= '0;
            end
        end
    end

    // job configuration captured on the command handshake, held for the whole job
    always_ff @(posedge clk) begin
        if (rst) begin
            stride_q    <= '0;
            pad_q       <= '0;
            wei_shape_q <= '0;
            ftm_shape_q <= '0;
            pass_last_q <= '0;
            last_para_q <= 1'b0;
        end else if (state == S_IDLE && bus.cmd_valid) begin
            stride_q    <= bus.cmd_stride;
            pad_q       <= bus.cmd_pad;
            wei_shape_q <= bus.cmd_wei_shape;
            ftm_shape_q <= bus.cmd_ftm_shape;
            pass_last_q <= (bus.cmd_n_pass == '0) ? '0 : bus.cmd_n_pass - 1'b1;
            last_para_q <= bus.cmd_last_para;
        end
    end

    // next state and decoded outputs; rd_en is a pure SWEEP decode so it never gaps mid-sweep
    always_comb begin
        state_nx        = state;
        cmd_ready       = 1'b0;
        busy            = 1'b1;
        rd_en           = 1'b0;
        rd_base_incr_en = 1'b0;
        wei_req         = 1'b0;
        done            = 1'b0;
        ftm_release     = 1'b0;
        case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (bus.cmd_valid) begin
                    state_nx = S_WAIT_FTM;
                end
            end
            S_WAIT_FTM: begin
                if (bus.ftm_ready) begin
                    state_nx = S_LOAD_WEI;
                end
            end
            S_LOAD_WEI: begin
                wei_req = !wei_sent;
                if (bus.wei_done) begin
                    state_nx = S_WAIT_SPACE;
                end
            end
            S_WAIT_SPACE: begin
                if (bus.out_space) begin
                    state_nx = S_SWEEP;
                end
            end
            S_SWEEP: begin
                rd_en           = 1'b1;
                rd_base_incr_en = last_para_q && last_pass;
                if (bus.rd_last) begin
                    state_nx = last_pass ? S_DONE : S_LOAD_WEI;
                end else if (wd_hit) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                done        = 1'b1;
                ftm_release = !timed_out;
                state_nx    = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

`ifdef SCHED_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

    logic [WD_W-1:0] wd_cnt;
    logic            err_q;

    // the counter restarts with every sweep; it fires on the TIMEOUT_CYC-th beat without rd_last
    assign wd_hit = (state == S_SWEEP) && !bus.rd_last && (wd_cnt == WD_W'(TIMEOUT_CYC - 1));

    // per-sweep cycle counter, timeout marker for DONE and sticky error
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt    <= '0;
            timed_out <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            if (state == S_SWEEP) begin
                wd_cnt <= wd_cnt + 1'b1;
            end else begin
                wd_cnt <= '0;
            end
            if (wd_hit) begin
                timed_out <= 1'b1;
                err_q     <= 1'b1;
            end else if (state == S_DONE) begin
                timed_out <= 1'b0;
            end
        end
    end

    assign bus.err = err_q;
`else
    assign wd_hit    = 1'b0;
    assign timed_out = 1'b0;
    assign bus.err   = 1'b0;
`endif

    assign bus.cmd_ready       = cmd_ready;
    assign bus.busy            = busy;
    assign bus.rd_en           = rd_en;
    assign bus.rd_base_incr_en = rd_base_incr_en;
    assign bus.wei_req         = wei_req;
    assign bus.done            = done;
    assign bus.ftm_release     = ftm_release;
    assign bus.stride          = stride_q;
    assign bus.pad             = pad_q;
    assign bus.wei_shape       = wei_shape_q;
    assign bus.ftm_shape       = ftm_shape_q;
    assign bus.pass_idx        = pass_idx_q;

endmodule

// File: tb/tb_conv_read_scheduler.sv
// tb/tb_conv_read_scheduler.sv - scoreboard bench for conv_read_scheduler with a behavioural reader
module tb_conv_read_scheduler;

    localparam int B_SHAPE = 25;
    localparam int B_PASS  = 8;
`ifdef SCHED_WATCHDOG_EN
    localparam int TO_CYC  = 50;
    localparam int SW_LEN  = 40;
`else
    localparam int SW_LEN  = 81;
`endif
    localparam logic [B_SHAPE-1:0] WEI_SH = {7'd1, 9'd3, 9'd3};
    localparam logic [B_SHAPE-1:0] FTM_SH = {7'd1, 9'd5, 9'd5};

    typedef struct {
        int len;
        int incr;
        int pidx;
    } burst_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    conv_read_scheduler_if #(.B_SHAPE(B_SHAPE), .B_PASS(B_PASS)) bus ();

    conv_read_scheduler #(
        .B_SHAPE(B_SHAPE),
        .B_PASS (B_PASS)
`ifdef SCHED_WATCHDOG_EN
        ,
        .TIMEOUT_CYC(TO_CYC)
`endif
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int     checks = 0;
    int     errors = 0;
    burst_t burst_q[$];
    int     done_q[$];

    int     cur_len = 0;
    int     bad_incr = 0;
    int     gap = 0;
    bit     gap_valid = 1'b0;
    bit     prev_rd_en = 1'b0;
    int     wei_cnt = 0;
    int     done_cnt = 0;
    int     stray_incr = 0;
    int     stray_rel = 0;
    bit     no_last = 1'b0;
    bit     force_last = 1'b0;
    burst_t exp_cur;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // reader model and scoreboard monitor, sampled just after each active edge
    always @(posedge clk) begin
        #1;
        if (bus.rd_en) begin
            if (cur_len == 0) begin
                if (burst_q.size() == 0) begin
                    check_eq("burst_unexpected", 1, 0);
                    exp_cur = '{0, 0, 0};
                end else begin
                    exp_cur = burst_q.pop_front();
                end
                if (gap_valid) check_eq("sweep_gap_ge2", gap >= 2, 1);
                check_eq("pass_idx", bus.pass_idx, exp_cur.pidx);
                bad_incr = 0;
            end
            cur_len++;
            if (bus.rd_base_incr_en !== exp_cur.incr[0]) bad_incr++;
            bus.rd_last = (cur_len == SW_LEN) && !no_last;
        end else begin
            if (cur_len != 0) begin
                check_eq("burst_len", cur_len, exp_cur.len);
                check_eq("burst_incr_beats_wrong", bad_incr, 0);
                gap_valid = 1'b1;
                gap = 1;
                cur_len = 0;
            end else begin
                gap++;
            end
            if (bus.rd_base_incr_en) stray_incr++;
            bus.rd_last = force_last;
        end
        if (bus.wei_req) wei_cnt++;
        if (bus.done) begin
            if (done_q.size() == 0) begin
                check_eq("done_unexpected", 1, 0);
            end else begin
                check_eq("ftm_release_at_done", bus.ftm_release, done_q.pop_front());
            end
            check_eq("done_after_rd_fall", prev_rd_en, 1);
            done_cnt++;
            gap_valid = 1'b0;
        end else if (bus.ftm_release) begin
            stray_rel++;
        end
        if (rst) gap_valid = 1'b0;
        prev_rd_en = bus.rd_en;
    end

    task automatic expect_job(input int np, input int lp, input int rel);
        int n;
        n = (np == 0) ? 1 : np;
        for (int p = 0; p < n; p++) begin
            burst_q.push_back('{SW_LEN, (lp != 0 && p == n - 1) ? 1 : 0, p});
        end
        done_q.push_back(rel);
    endtask

    task automatic issue_cmd(input int np, input bit lp, input logic [1:0] st, input logic [1:0] pd);
        @(negedge clk);
        check_eq("cmd_ready_before_cmd", bus.cmd_ready, 1);
        bus.cmd_valid     = 1'b1;
        bus.cmd_stride    = st;
        bus.cmd_pad       = pd;
        bus.cmd_wei_shape = WEI_SH;
        bus.cmd_ftm_shape = FTM_SH;
        bus.cmd_n_pass    = B_PASS'(np);
        bus.cmd_last_para = lp;
        @(negedge clk);
        bus.cmd_valid     = 1'b0;
        bus.cmd_stride    = ~st;
        bus.cmd_pad       = ~pd;
        bus.cmd_wei_shape = '1;
        bus.cmd_ftm_shape = '0;
        bus.cmd_n_pass    = '1;
        bus.cmd_last_para = ~lp;
    endtask

    task automatic wait_done(input string tag);
        int d0;
        int n;
        d0 = done_cnt;
        n = 0;
        while (done_cnt == d0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, done_cnt - d0, 1);
        @(negedge clk);
        check_eq("idle_after_job", bus.cmd_ready, 1);
        check_eq("pass_idx_cleared", bus.pass_idx, 0);
    endtask

    initial begin
        int  w0;
        int  lat;
        int  n;
        bit  seen;

        rst               = 1'b1;
        bus.cmd_valid     = 1'b0;
        bus.cmd_stride    = '0;
        bus.cmd_pad       = '0;
        bus.cmd_wei_shape = '0;
        bus.cmd_ftm_shape = '0;
        bus.cmd_n_pass    = '0;
        bus.cmd_last_para = 1'b0;
        bus.ftm_ready     = 1'b1;
        bus.wei_done      = 1'b1;
        bus.out_space     = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_cmd_ready", bus.cmd_ready, 1);
        check_eq("rst_busy", bus.busy, 0);
        check_eq("rst_rd_en", bus.rd_en, 0);
        check_eq("rst_done", bus.done, 0);
        check_eq("rst_pass_idx", bus.pass_idx, 0);
        check_eq("rst_stride", bus.stride, 0);
        check_eq("rst_err", bus.err, 0);
        rst = 1'b0;

        // basic single pass with latency and held-configuration checks
        expect_job(1, 1, 1);
        w0 = wei_cnt;
        issue_cmd(1, 1'b1, 2'd1, 2'd0);
        lat = 1;
        while (!bus.rd_en && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check_eq("first_rd_lat_ge3", lat >= 3, 1);
        check_eq("first_rd_seen", bus.rd_en, 1);
        check_eq("held_stride", bus.stride, 2'd1);
        check_eq("held_pad", bus.pad, 2'd0);
        check_eq("held_wei_shape", bus.wei_shape, WEI_SH);
        check_eq("held_ftm_shape", bus.ftm_shape, FTM_SH);
        check_eq("busy_in_sweep", bus.busy, 1);
        wait_done("done_basic");
        check_eq("wei_req_basic", wei_cnt - w0, 1);

        // three passes over the same map
        expect_job(3, 1, 1);
        w0 = wei_cnt;
        issue_cmd(3, 1'b1, 2'd2, 2'd1);
        wait_done("done_multi");
        check_eq("wei_req_multi", wei_cnt - w0, 3);

        // not the last parameter set: base never advances
        expect_job(2, 0, 1);
        issue_cmd(2, 1'b0, 2'd3, 2'd2);
        wait_done("done_not_last");

        // zero pass count behaves as one
        expect_job(0, 1, 1);
        w0 = wei_cnt;
        issue_cmd(0, 1'b1, 2'd1, 2'd1);
        wait_done("done_npass0");
        check_eq("wei_req_npass0", wei_cnt - w0, 1);

        // ftm gating, single wei_req, backpressure and spurious rd_last
        bus.ftm_ready = 1'b0;
        bus.wei_done  = 1'b0;
        bus.out_space = 1'b0;
        expect_job(1, 1, 1);
        w0 = wei_cnt;
        issue_cmd(1, 1'b1, 2'd2, 2'd1);
        repeat (5) @(negedge clk);
        check_eq("wait_ftm_busy", bus.busy, 1);
        check_eq("wait_ftm_no_wei", wei_cnt - w0, 0);
        bus.ftm_ready = 1'b1;
        repeat (6) @(negedge clk);
        check_eq("wei_req_once", wei_cnt - w0, 1);
        bus.ftm_ready = 1'b0;
        bus.wei_done  = 1'b1;
        @(negedge clk);
        bus.wei_done  = 1'b0;
        force_last    = 1'b1;
        seen          = 1'b0;
        w0            = done_cnt;
        repeat (20) begin
            @(negedge clk);
            if (bus.rd_en) seen = 1'b1;
        end
        check_eq("no_rd_without_space", seen, 0);
        check_eq("idle_rd_last_ignored", done_cnt - w0, 0);
        force_last = 1'b0;
        @(negedge clk);
        bus.out_space = 1'b1;
        n = 0;
        while (!bus.rd_en && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("rd_after_space", bus.rd_en, 1);
        repeat (10) @(negedge clk);
        bus.out_space = 1'b0;
        wait_done("done_backpressure");
        bus.ftm_ready = 1'b1;
        bus.wei_done  = 1'b1;
        bus.out_space = 1'b1;

        // reset in the middle of a sweep, then a clean job
        burst_q.push_back('{SW_LEN / 2, 1, 0});
        issue_cmd(1, 1'b1, 2'd1, 2'd0);
        n = 0;
        while (cur_len != SW_LEN / 2 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check_eq("reached_mid_sweep", cur_len, SW_LEN / 2);
        rst = 1'b1;
        @(negedge clk);
        check_eq("rst_mid_rd_en", bus.rd_en, 0);
        check_eq("rst_mid_cmd_ready", bus.cmd_ready, 1);
        check_eq("rst_mid_busy", bus.busy, 0);
        rst = 1'b0;
        expect_job(1, 1, 1);
        issue_cmd(1, 1'b1, 2'd1, 2'd0);
        wait_done("done_after_rst");

`ifdef SCHED_WATCHDOG_EN
        // reader never signals its last beat
        burst_q.push_back('{TO_CYC, 1, 0});
        done_q.push_back(0);
        no_last = 1'b1;
        issue_cmd(1, 1'b1, 2'd1, 2'd0);
        wait_done("done_watchdog");
        no_last = 1'b0;
        check_eq("wd_err_set", bus.err, 1);
        repeat (3) @(negedge clk);
        check_eq("wd_err_sticky", bus.err, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
`endif

        repeat (5) @(negedge clk);
        check_eq("err_clear", bus.err, 0);
        check_eq("bursts_left", burst_q.size(), 0);
        check_eq("dones_left", done_q.size(), 0);
        check_eq("stray_incr", stray_incr, 0);
        check_eq("stray_release", stray_rel, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv_read_scheduler.md
Name: conv_read_scheduler

Overview:
Job-level controller that sequences the strided feature-map buffer reader for one convolution layer tile.
- Accepts a layer command and waits for the feature map to be resident.
- For each output-channel pass: requests a weight load, waits for downstream space, then holds the reader's read enable for exactly one full sweep.
- Drives the reader's static configuration and asserts base-increment only on the final pass of the last parameter set, so the buffer base advances exactly once per feature map.

Parameters:
B_SHAPE, 25, width of packed shape words ({n_wrap_c[6:0], h[8:0], w[8:0]})
B_PASS, 8, width of pass count
TIMEOUT_CYC, 1048576, watchdog limit in cycles per sweep (optional feature only)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
cmd_valid  in  1  command valid
cmd_ready  out  1  high only in IDLE
cmd_stride  in  2  conv stride, 1..3
cmd_pad  in  2  padding
cmd_wei_shape  in  B_SHAPE  weight shape
cmd_ftm_shape  in  B_SHAPE  feature-map shape
cmd_n_pass  in  B_PASS  number of sweeps over the same ftm, must be >=1
cmd_last_para  in  1  final parameter set: base may advance
ftm_ready  in  1  level: ftm fully written to buffer
ftm_release  out  1  one-cycle pulse: ftm consumed
wei_req  out  1  one-cycle pulse: load next weight set
wei_done  in  1  pulse: weights loaded
out_space  in  1  level: downstream can absorb one full sweep
rd_en  out  1  reader read enable
rd_last  in  1  reader final-beat indication (valid when rd_en=1)
rd_base_incr_en  out  1  reader base-increment enable
stride  out  2  registered cmd_stride
pad  out  2  registered cmd_pad
wei_shape  out  B_SHAPE  registered
ftm_shape  out  B_SHAPE  registered
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at job end
pass_idx  out  B_PASS  current pass
err  out  1  sticky error flag (optional feature)

Behaviour:
Reset values:
- All outputs 0, except cmd_ready=1.
- State IDLE, pass_idx=0.
- Reset asserted mid-sweep drops rd_en on the next edge; the reader restarts cleanly from x=y=0.

Command capture:
- Handshake when cmd_valid && cmd_ready.
- stride, pad, wei_shape, ftm_shape, n_pass and last_para are registered on that edge and held constant until the job leaves DONE.
- cmd_n_pass=0 is treated as 1.

State machine:
- IDLE -> WAIT_FTM on handshake.
- WAIT_FTM -> LOAD_WEI when ftm_ready=1.
- LOAD_WEI: wei_req pulses on the entry cycle only. -> WAIT_SPACE on wei_done. A wei_done arriving in the same cycle as wei_req is accepted.
- WAIT_SPACE -> SWEEP when out_space=1.
- SWEEP:
  - rd_en=1 every cycle, with no stalls. The reader clears x/y whenever rd_en=0, so rd_en must never deassert mid-sweep.
  - out_space is ignored once SWEEP is entered.
  - rd_base_incr_en = last_para && (pass_idx == n_pass-1) && state==SWEEP.
  - On rd_last=1 (the last beat), next state:
    - pass_idx == n_pass-1 -> DONE.
    - otherwise -> LOAD_WEI, with pass_idx+1.
  - Consecutive sweeps are separated by at least 2 cycles of rd_en=0 (LOAD_WEI, WAIT_SPACE).
- DONE: done=1 and ftm_release=1 for exactly one cycle, pass_idx cleared. -> IDLE.

Latency:
- First rd_en occurs no earlier than 3 cycles after the handshake, with ftm_ready, wei_done and out_space all already high.
- rd_last observed with rd_en=1 means rd_en=0 on the following cycle.

Boundary conditions:
- rd_last while rd_en=0 is ignored.
- ftm_ready dropping after WAIT_FTM is ignored.
- wei_done outside LOAD_WEI is ignored.
- The pass counter does not wrap for n_pass up to 2^B_PASS-1.

Optional Feature:
Macro SCHED_WATCHDOG_EN.
- Defined: a cycle counter runs in SWEEP. If it reaches TIMEOUT_CYC without rd_last, then:
  - err is set (sticky until rst);
  - rd_en drops;
  - the block goes to DONE with done pulsed and ftm_release suppressed.
- Undefined: err is tied to 0 and there is no counter.

Test Plan:
- Basic sweep: wei 3x3, n_wrap_c=1, ftm 5x5, stride=1, pad=0, n_pass=1, last_para=1, all handshakes high -> rd_en high for exactly 81 consecutive cycles; rd_base_incr_en high for the same 81 cycles; done and ftm_release each pulse once, 1 cycle after rd_en falls.
- Multi-pass: same configuration with n_pass=3, last_para=1 -> three 81-cycle rd_en bursts separated by >=2 low cycles; wei_req pulses 3 times; rd_base_incr_en high only during burst 3; pass_idx steps 0,1,2.
- Not-last parameter set: last_para=0, n_pass=2 -> rd_base_incr_en never asserts; done pulses once.
- Backpressure: out_space=0 for 20 cycles after wei_done -> rd_en stays 0 for those 20 cycles. Dropping out_space mid-sweep leaves rd_en continuously high until rd_last.
- Reset mid-sweep: rst at beat 40 -> rd_en=0, cmd_ready=1, busy=0 next cycle. A new command then produces a full 81-beat sweep.
- SCHED_WATCHDOG_EN defined: TIMEOUT_CYC=50, rd_last held 0 -> rd_en drops after 50 cycles; err=1; done pulses; ftm_release stays 0.
